// File: rtl/reduce_add_uint8.sv
`default_nettype none
// ============================================================================
//  Module   : reduce_add_uint8
//  Purpose  : Sequential wrapping-uint8 sum reduction. Accumulates N valid
//             8-bit products and emits their modulo-256 sum as a single
//             registered output beat. Invalid cycles are bubbles and do not
//             advance the reduction. There is no backpressure.
//  Ports    : clk        - rising-edge clock
//             rst        - synchronous active-high reset
//             I          - 8-bit unsigned input element
//             valid_in   - I carries a real element this cycle
//             O          - reduced sum, held until the next result
//             valid_out  - single-cycle pulse, O holds a new result
//             busy       - a reduction is partially accumulated
//  Revision : 1.0 - initial release
// ============================================================================
module reduce_add_uint8 #(
   parameter int N = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] I,
   input  logic       valid_in,
   output logic [7:0] O,
   output logic       valid_out,
   output logic       busy
);

   localparam int               CNT_W  = $clog2(N) + 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

   logic [7:0]       r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_o;
   logic             r_valid_out;
   logic             r_busy;

   logic [7:0]       w_sum;
   logic             w_last;
   logic [7:0]       w_acc_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [7:0]       w_o_nxt;
   logic             w_valid_out_nxt;
   logic             w_busy_nxt;

   // The 8-bit sum drops the carry out of bit 7, giving uint8 wrap semantics.
   assign w_sum  = r_acc + I;
   assign w_last = (r_cnt == C_LAST);

   always_comb begin
      w_acc_nxt       = r_acc;
      w_cnt_nxt       = r_cnt;
      w_o_nxt         = r_o;
      w_valid_out_nxt = 1'b0;
      if (valid_in) begin
         if (w_last) begin
            // Final element: publish the sum and restart immediately so the
            // next valid cycle is element 0 of a new reduction. With N = 1
            // this branch is always taken, so acc never leaves zero.
            w_o_nxt         = w_sum;
            w_valid_out_nxt = 1'b1;
            w_acc_nxt       = 8'd0;
            w_cnt_nxt       = '0;
         end else begin
            w_acc_nxt = w_sum;
            w_cnt_nxt = r_cnt + C_ONE;
         end
      end
      // busy reflects the count that will exist after this edge.
      w_busy_nxt = (w_cnt_nxt != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc       <= 8'd0;
         r_cnt       <= '0;
         r_o         <= 8'd0;
         r_valid_out <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_acc       <= w_acc_nxt;
         r_cnt       <= w_cnt_nxt;
         r_o         <= w_o_nxt;
         r_valid_out <= w_valid_out_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   assign O         = r_o;
   assign valid_out = r_valid_out;
   assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_reduce_add_uint8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reduce_add_uint8
//  Purpose  : Self-checking bench for reduce_add_uint8. Three instances with
//             N = 4, 1 and 3 run side by side against a reference model that
//             keeps a plain running count and unbounded sum per instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reduce_add_uint8;

   logic       clk;
   logic       r_rst   [3];
   logic       r_vin   [3];
   logic [7:0] r_din   [3];
   logic [7:0] w_o     [3];
   logic       w_vo    [3];
   logic       w_busy  [3];

   int c_nval [3] = '{4, 1, 3};

   int r_checks = 0;
   int r_errors = 0;

   // reference model state
   int m_cnt  [3];
   int m_sum  [3];
   int m_o    [3];
   int m_vo   [3];
   int m_busy [3];

   reduce_add_uint8 #(.N(4)) u_dut4 (
      .clk(clk), .rst(r_rst[0]), .I(r_din[0]), .valid_in(r_vin[0]),
      .O(w_o[0]), .valid_out(w_vo[0]), .busy(w_busy[0])
   );
   reduce_add_uint8 #(.N(1)) u_dut1 (
      .clk(clk), .rst(r_rst[1]), .I(r_din[1]), .valid_in(r_vin[1]),
      .O(w_o[1]), .valid_out(w_vo[1]), .busy(w_busy[1])
   );
   reduce_add_uint8 #(.N(3)) u_dut3 (
      .clk(clk), .rst(r_rst[2]), .I(r_din[2]), .valid_in(r_vin[2]),
      .O(w_o[2]), .valid_out(w_vo[2]), .busy(w_busy[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      r_checks++;
      if (got !== exp) begin
         r_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock: let the edge happen, update the model from the inputs that
   // were sampled, compare every instance, then return inputs to idle.
   task automatic cycle();
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         if (r_rst[k]) begin
            m_cnt[k] = 0; m_sum[k] = 0; m_o[k] = 0; m_vo[k] = 0;
         end else if (r_vin[k]) begin
            m_sum[k] += int'(r_din[k]);
            m_cnt[k]++;
            if (m_cnt[k] == c_nval[k]) begin
               m_o[k]   = m_sum[k] % 256;
               m_vo[k]  = 1;
               m_cnt[k] = 0;
               m_sum[k] = 0;
            end else begin
               m_vo[k] = 0;
            end
         end else begin
            m_vo[k] = 0;
         end
         m_busy[k] = (m_cnt[k] != 0) ? 1 : 0;
         chk($sformatf("o[%0d]", k),     int'(w_o[k]),    m_o[k]);
         chk($sformatf("vo[%0d]", k),    int'(w_vo[k]),   m_vo[k]);
         chk($sformatf("busy[%0d]", k),  int'(w_busy[k]), m_busy[k]);
      end
      for (int k = 0; k < 3; k++) begin
         r_vin[k] = 1'b0;
         r_rst[k] = 1'b0;
         r_din[k] = 8'd0;
      end
   endtask

   task automatic feed(input int k, input int d);
      r_vin[k] = 1'b1;
      r_din[k] = 8'(d);
   endtask

   initial begin
      int pulses;
      logic [7:0] a [3];
      logic [7:0] b [3];
      logic [7:0] prod [3];

      for (int k = 0; k < 3; k++) begin
         m_cnt[k] = 0; m_sum[k] = 0; m_o[k] = 0; m_vo[k] = 0; m_busy[k] = 0;
         r_vin[k] = 1'b0; r_rst[k] = 1'b0; r_din[k] = 8'd0;
      end

      // reset with aggressive input activity
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < 3; k++) begin
            r_rst[k] = 1'b1; feed(k, 8'hFF);
         end
         cycle();
      end
      cycle();

      // basic reduction N = 4
      for (int i = 1; i <= 4; i++) begin
         feed(0, i);
         cycle();
      end
      chk("basic_o", int'(w_o[0]), 10);
      chk("basic_vo", int'(w_vo[0]), 1);
      cycle();
      chk("basic_vo_drop", int'(w_vo[0]), 0);

      // wrap-around with bubbles
      pulses = 0;
      feed(0, 200); cycle(); pulses += int'(w_vo[0]);
      cycle();      pulses += int'(w_vo[0]);
      cycle();      pulses += int'(w_vo[0]);
      feed(0, 100); cycle(); pulses += int'(w_vo[0]);
      feed(0, 128); cycle(); pulses += int'(w_vo[0]);
      feed(0, 129); cycle(); pulses += int'(w_vo[0]);
      chk("wrap_o", int'(w_o[0]), 45);
      for (int c = 0; c < 4; c++) begin
         cycle(); pulses += int'(w_vo[0]);
      end
      chk("wrap_pulses", pulses, 1);
      chk("wrap_hold", int'(w_o[0]), 45);

      // back-to-back reductions
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         feed(0, 1);
         cycle();
         pulses += int'(w_vo[0]);
         if (i == 3 || i == 7) chk("b2b_o", int'(w_o[0]), 4);
      end
      chk("b2b_pulses", pulses, 2);

      // mid-reduction reset discards the 7s
      feed(0, 7); cycle();
      feed(0, 7); cycle();
      r_rst[0] = 1'b1; cycle();
      for (int i = 0; i < 4; i++) begin
         feed(0, 1); cycle();
      end
      chk("rst_mid_o", int'(w_o[0]), 4);
      chk("rst_mid_vo", int'(w_vo[0]), 1);

      // N = 1 pass-through
      feed(1, 8'h10); cycle();
      chk("pass_o0", int'(w_o[1]), 16);
      feed(1, 8'h20); cycle();
      chk("pass_o1", int'(w_o[1]), 32);
      feed(1, 8'h30); cycle();
      chk("pass_o2", int'(w_o[1]), 48);
      chk("pass_vo", int'(w_vo[1]), 1);
      cycle();
      chk("pass_vo_end", int'(w_vo[1]), 0);

      // chained behind a 3-cycle multiplier, N = 3
      a = '{8'd2, 8'd4, 8'd16};
      b = '{8'd3, 8'd5, 8'd16};
      for (int i = 0; i < 3; i++) prod[i] = 8'((int'(a[i]) * int'(b[i])) % 256);
      for (int t = 0; t < 6; t++) begin
         if (t >= 3) feed(2, int'(prod[t-3]));
         cycle();
      end
      chk("mac_o", int'(w_o[2]), 26);
      chk("mac_vo", int'(w_vo[2]), 1);

      // randomized traffic with occasional resets
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 3; k++) begin
            if ($urandom_range(0, 3) != 0) feed(k, int'($urandom_range(0, 255)));
            if ($urandom_range(0, 60) == 0) r_rst[k] = 1'b1;
         end
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/reduce_add_uint8.md
# reduce_add_uint8

Sequential reduction stage directly downstream of the 8-bit multiplier: consumes one 8-bit product per valid cycle and emits the wrapping 8-bit sum of every N consecutive valid products as one valid output beat. Together with the multiplier it forms the multiply-accumulate tail of a dot-product or convolution pipeline. Invalid input cycles are bubbles: they are ignored and do not advance the reduction. The block has no backpressure.

## Interface
- `N`, default 4: number of valid inputs per reduction. Legal range 1..256.
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `I`, input, 8: unsigned product from the upstream multiplier.
- `valid_in`, input, 1: `I` is a real element this cycle.
- `O`, output, 8: unsigned reduced sum. Registered.
- `valid_out`, output, 1: `O` holds a new result this cycle. Registered.
- `busy`, output, 1: a reduction is partially accumulated (count ≠ 0). Registered.

## Operation
- Internal state:
  - `acc[7:0]`: partial sum.
  - `cnt`: number of valid elements taken so far, width clog2(N)+1, range 0..N-1.
- Arithmetic: all sums are modulo 2^8. Carries out of bit 7 are discarded and no flag is raised, matching uint8 semantics.
- Per cycle when `rst` = 0:
  - `valid_in` = 0:
    - `acc`, `cnt` and `O` hold.
    - `valid_out` <= 0.
  - `valid_in` = 1 and `cnt` < N-1:
    - `acc` <= `acc` + `I`.
    - `cnt` <= `cnt` + 1.
    - `valid_out` <= 0.
  - `valid_in` = 1 and `cnt` = N-1 (final element):
    - `O` <= `acc` + `I`.
    - `valid_out` <= 1.
    - `acc` <= 0 and `cnt` <= 0.
    - The next valid cycle starts a fresh reduction, so back-to-back reductions have no dead cycle.
- `busy` <= 1 when the next `cnt` value is nonzero, else 0.
- N = 1:
  - Every valid input is registered straight to `O` with `valid_out` = 1.
  - `acc` stays 0 and `busy` stays 0.
- `O` holds its last result indefinitely while `valid_out` = 0. Downstream must sample `O` only when `valid_out` = 1.
- Reset:
  - `rst` = 1 at an edge forces `acc` = 0, `cnt` = 0, `O` = 0, `valid_out` = 0, `busy` = 0.
  - `valid_in` is ignored in a reset cycle.
  - Reset mid-reduction discards the partial sum. The first valid element after reset is element 0 of a new reduction.

## Timing
- Latency: `valid_out` rises exactly 1 cycle after the edge that samples the final (Nth) valid element.
- End-to-end from the multiplier operands to the reduced sum: 3 + 1 = 4 cycles after the last operand pair.
- Throughput:
  - One input element per cycle.
  - One result every N valid cycles.
  - Bubbles stretch the reduction but never corrupt it.
- `valid_out` is a single-cycle pulse per result. With N = 1 and continuous `valid_in`, it stays high every cycle.
- After reset deassertion, the first edge may already accept a valid input.

## Test plan
- Reset values:
  - Hold `rst` = 1 for 2 cycles with `valid_in` = 1 and `I` = 0xFF.
  - Require `O` = 0, `valid_out` = 0, `busy` = 0 throughout and after release.
- Basic reduction, N = 4:
  - Feed 1, 2, 3, 4 on consecutive cycles.
  - Require one `valid_out` pulse with `O` = 10, one cycle after the 4th input.
  - Require `busy` = 1 after inputs 1–3 and 0 after input 4.
- Wrap-around and bubbles, N = 4:
  - Feed 200, 100, 0x80, 0x81, with 2 invalid cycles inserted after the first element.
  - Require `O` = (200+100+128+129) mod 256 = 45, and only one pulse.
  - Require `O` to hold 45 while idle.
- Back-to-back and mid-operation reset, N = 4:
  - Feed 8 continuous valid 1s. Require pulses with `O` = 4 at cycles 5 and 9 relative to the first input.
  - Then feed 7, 7, assert `rst` for 1 cycle, then feed 1, 1, 1, 1.
  - Require `O` = 4, with no contribution from the 7s.
- N = 1 pass-through:
  - Feed 0x10, 0x20, 0x30 continuously.
  - Require `valid_out` high for 3 cycles with `O` = 0x10, 0x20, 0x30, each delayed by 1 cycle.
- Chained with the multiplier, N = 3:
  - Feed pairs (2,3), (4,5), (16,16), aligned on `valid_in` through a 3-cycle delay.
  - Require `O` = (6+20+0) = 26 (16×16 = 256 wraps to 0), 4 cycles after the last pair.
